// File: rtl/exe_mem_pkg.sv
// Shared types for the EXE->MEM pipeline boundary: memory op encoding, exception codes,
// FSM states and the registered entry layout.
package exe_mem_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LW  = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        SW  = 4'd8
    } mem_op_t;

    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Exception code lives beside the struct because its width is a module parameter.
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] pc;
        logic [31:0] bad_vaddr;
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic        reg_wr;
        mem_op_t     mem_op;
        logic        mem_req;
        logic [3:0]  be;
        logic        exc_valid;
        logic        in_delay_slot;
    } exe_mem_entry_t;

endpackage

// File: rtl/exe_mem_stage_reg_if.sv
// EXE->MEM boundary bundle: EXE-side request, MEM-side registered entry and the flush strobe.
interface exe_mem_stage_reg_if #(parameter int EXC_W = 5);
    import exe_mem_pkg::*;

    logic             Flush;
    logic             EXE_Valid;
    logic             EXE_Ready;
    logic [31:0]      EXE_ALUOut;
    logic             EXE_Overflow_valid;
    logic [31:0]      EXE_PC;
    logic [4:0]       EXE_Dst;
    logic             EXE_RegWr;
    mem_op_t          EXE_MemOp;
    logic [31:0]      EXE_StoreData;
    logic             EXE_ExcValid;
    logic [EXC_W-1:0] EXE_ExcCode;
    logic             EXE_InDelaySlot;

    logic             MEM_Valid;
    logic             MEM_Ready;
    logic [31:0]      MEM_ALUOut;
    logic [31:0]      MEM_PC;
    logic [4:0]       MEM_Dst;
    logic             MEM_RegWr;
    mem_op_t          MEM_MemOp;
    logic             MEM_MemReq;
    logic [31:0]      MEM_WData;
    logic [3:0]       MEM_BE;
    logic             MEM_ExcValid;
    logic [EXC_W-1:0] MEM_ExcCode;
    logic [31:0]      MEM_BadVAddr;
    logic             MEM_InDelaySlot;

    modport slave (
        input  Flush, EXE_Valid, EXE_ALUOut, EXE_Overflow_valid, EXE_PC, EXE_Dst, EXE_RegWr,
               EXE_MemOp, EXE_StoreData, EXE_ExcValid, EXE_ExcCode, EXE_InDelaySlot, MEM_Ready,
        output EXE_Ready, MEM_Valid, MEM_ALUOut, MEM_PC, MEM_Dst, MEM_RegWr, MEM_MemOp,
               MEM_MemReq, MEM_WData, MEM_BE, MEM_ExcValid, MEM_ExcCode, MEM_BadVAddr,
               MEM_InDelaySlot
    );

    modport master (
        output Flush, EXE_Valid, EXE_ALUOut, EXE_Overflow_valid, EXE_PC, EXE_Dst, EXE_RegWr,
               EXE_MemOp, EXE_StoreData, EXE_ExcValid, EXE_ExcCode, EXE_InDelaySlot, MEM_Ready,
        input  EXE_Ready, MEM_Valid, MEM_ALUOut, MEM_PC, MEM_Dst, MEM_RegWr, MEM_MemOp,
               MEM_MemReq, MEM_WData, MEM_BE, MEM_ExcValid, MEM_ExcCode, MEM_BadVAddr,
               MEM_InDelaySlot
    );

endinterface

// File: rtl/mem_lane_gen.sv
// Combinational store-lane replication, byte enables and alignment check for one memory op.
// Zero latency; no flow control of its own.
module mem_lane_gen
    import exe_mem_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign,
    output logic        o_is_store
);

    always_comb begin
        o_wdata    = '0;
        o_be       = '0;
        o_misalign = 1'b0;
        o_is_store = 1'b0;
        case (i_op)
            LB, LBU: o_be = 4'b0001 << i_addr_lo;
            LH, LHU: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            LW: begin
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            SB: begin
                o_wdata    = {4{i_data[7:0]}};
                o_be       = 4'b0001 << i_addr_lo;
                o_is_store = 1'b1;
            end
            SH: begin
                o_wdata    = {2{i_data[15:0]}};
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
                o_is_store = 1'b1;
            end
            SW: begin
                o_wdata    = i_data;
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
                o_is_store = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register: merges exceptions and builds store lanes on entry, then holds
// entries in main + skid registers (1-cycle latency, FIFO order, EXE_Ready registered when SKID_EN).
module exe_mem_stage_reg
    import exe_mem_pkg::*;
#(
    parameter bit SKID_EN = 1'b1,
    parameter int EXC_W   = 5
) (
    input  logic clk,
    input  logic rst,
    exe_mem_stage_reg_if.slave bus
);

    logic [31:0]      w_lane_wdata;
    logic [3:0]       w_lane_be;
    logic             w_misalign;
    logic             w_is_store;
    logic             w_exc;
    logic [EXC_W-1:0] w_code;
    exe_mem_entry_t   w_entry;
    logic             w_in;
    logic             w_out;

    stage_state_t     r_state;
    logic             r_rdy;
    exe_mem_entry_t   r_main;
    exe_mem_entry_t   r_skid;
    logic [EXC_W-1:0] r_main_code;
    logic [EXC_W-1:0] r_skid_code;

    mem_lane_gen u_lane (
        .i_op       (bus.EXE_MemOp),
        .i_addr_lo  (bus.EXE_ALUOut[1:0]),
        .i_data     (bus.EXE_StoreData),
        .o_wdata    (w_lane_wdata),
        .o_be       (w_lane_be),
        .o_misalign (w_misalign),
        .o_is_store (w_is_store)
    );

    // Priority: upstream, overflow, load misalign, store misalign.
    always_comb begin
        w_exc  = bus.EXE_ExcValid | bus.EXE_Overflow_valid | w_misalign;
        w_code = '0;
        if (bus.EXE_ExcValid)            w_code = bus.EXE_ExcCode;
        else if (bus.EXE_Overflow_valid) w_code = EXC_W'(EXC_OV);
        else if (w_misalign)             w_code = w_is_store ? EXC_W'(EXC_ADES) : EXC_W'(EXC_ADEL);

        w_entry               = '0;
        w_entry.alu_out       = bus.EXE_ALUOut;
        w_entry.pc            = bus.EXE_PC;
        w_entry.dst           = bus.EXE_Dst;
        w_entry.mem_op        = bus.EXE_MemOp;
        w_entry.wdata         = w_lane_wdata;
        w_entry.in_delay_slot = bus.EXE_InDelaySlot;
        w_entry.exc_valid     = w_exc;
        w_entry.reg_wr        = bus.EXE_RegWr & ~w_exc;
        w_entry.mem_req       = (bus.EXE_MemOp != NOP) & ~w_exc;
        w_entry.be            = w_exc ? 4'b0000 : w_lane_be;
        w_entry.bad_vaddr     = (!bus.EXE_ExcValid && !bus.EXE_Overflow_valid && w_misalign)
                                ? bus.EXE_ALUOut : 32'h0;
    end

    assign bus.MEM_Valid = (r_state != ST_EMPTY);
    assign bus.EXE_Ready = SKID_EN ? r_rdy : (!bus.MEM_Valid || bus.MEM_Ready);
    assign w_in          = bus.EXE_Valid && bus.EXE_Ready;
    assign w_out         = bus.MEM_Valid && bus.MEM_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_rdy       <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
            r_main_code <= '0;
            r_skid_code <= '0;
        end else if (bus.Flush) begin
            r_state     <= ST_EMPTY;
            r_rdy       <= 1'b1;
            r_main      <= '0;
            r_main_code <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in) begin
                    r_main      <= w_entry;
                    r_main_code <= w_code;
                    r_state     <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (w_in && w_out) begin
                        r_main      <= w_entry;
                        r_main_code <= w_code;
                    end else if (w_in && SKID_EN) begin
                        r_skid      <= w_entry;
                        r_skid_code <= w_code;
                        r_state     <= ST_FULL;
                        r_rdy       <= 1'b0;
                    end else if (w_out) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: if (w_out) begin
                    r_main      <= r_skid;
                    r_main_code <= r_skid_code;
                    r_state     <= ST_BUSY;
                    r_rdy       <= 1'b1;
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.MEM_ALUOut      = r_main.alu_out;
    assign bus.MEM_PC          = r_main.pc;
    assign bus.MEM_Dst         = r_main.dst;
    assign bus.MEM_RegWr       = r_main.reg_wr;
    assign bus.MEM_MemOp       = r_main.mem_op;
    assign bus.MEM_MemReq      = r_main.mem_req;
    assign bus.MEM_WData       = r_main.wdata;
    assign bus.MEM_BE          = r_main.be;
    assign bus.MEM_ExcValid    = r_main.exc_valid;
    assign bus.MEM_ExcCode     = r_main_code;
    assign bus.MEM_BadVAddr    = r_main.bad_vaddr;
    assign bus.MEM_InDelaySlot = r_main.in_delay_slot;

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
Pipeline boundary directly downstream of the EXE-stage ALU; it consumes the ALU result and overflow flag. On entry it merges exceptions (upstream, integer overflow, address error) and builds the store-lane data and byte enables. It registers everything for the MEM stage behind a valid/ready handshake with a 2-entry skid buffer, so EXE_Ready is a flop output.

Parameters:
SKID_EN, 1, 1 = 2-entry skid buffer with registered EXE_Ready; 0 = single register, EXE_Ready = !MEM_Valid || MEM_Ready.
EXC_W, 5, width of the exception-code field.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
Flush  in  1  squash all held entries (exception/ERET from a later stage)
EXE_Valid  in  1  EXE presents an instruction
EXE_Ready  out  1  this block can accept
EXE_ALUOut  in  32  ALU result; the memory address for loads/stores
EXE_Overflow_valid  in  1  ALU signed overflow (ADD/SUB)
EXE_PC  in  32  instruction PC
EXE_Dst  in  5  destination register
EXE_RegWr  in  1  writes the register file
EXE_MemOp  in  4  mem_op_t
EXE_StoreData  in  32  raw rt value
EXE_ExcValid  in  1  exception raised upstream
EXE_ExcCode  in  EXC_W  upstream exception code
EXE_InDelaySlot  in  1  branch delay slot flag
MEM_Valid  out  1  entry presented to MEM
MEM_Ready  in  1  MEM accepts
MEM_ALUOut, MEM_PC  out  32 each  registered copies
MEM_Dst  out  5  registered copy
MEM_RegWr  out  1  forced 0 if the entry carries an exception
MEM_MemOp  out  4  registered copy
MEM_MemReq  out  1  memory access required: MemOp != NOP and no exception
MEM_WData  out  32  lane-replicated store data
MEM_BE  out  4  byte enables
MEM_ExcValid  out  1  exception present
MEM_ExcCode  out  EXC_W  exception code
MEM_BadVAddr  out  32  faulting address (AdEL/AdES), else 0
MEM_InDelaySlot  out  1  registered copy

Behaviour:
- Reset: all MEM_* outputs 0, MEM_Valid=0, EXE_Ready=1, FSM=EMPTY.
- Transfer in: EXE_Valid&&EXE_Ready. Transfer out: MEM_Valid&&MEM_Ready. Accept-to-MEM_Valid latency is 1 cycle.
- FSM states (SKID_EN=1):
  - EMPTY: accept -> BUSY.
  - BUSY (main valid): in&&!out -> FULL (incoming entry goes to skid); out&&!in -> EMPTY; in&&out -> BUSY (main reloads).
  - FULL: EXE_Ready=0; out -> BUSY (skid moves to main).
- Ordering: entries are strictly FIFO; the skid entry is never emitted before main.
- Flush: next edge -> EMPTY; every entry is invalid, including one accepted in the same cycle. Flush beats all other events. EXE_Ready=1 the cycle after.
- Exception merge, computed at entry, first match wins:
  1. EXE_ExcValid -> upstream code.
  2. EXE_Overflow_valid -> 0x0C (Ov).
  3. Misaligned load (LH/LHU with addr[0]; LW with addr[1:0]!=0) -> 0x04 (AdEL), BadVAddr=ALUOut.
  4. Misaligned store (SH/SW, same rule) -> 0x05 (AdES), BadVAddr=ALUOut.
- Any exception: RegWr=0, MemReq=0, BE=0.
- Lanes, a=ALUOut[1:0]:
  - SB: WData={4{d[7:0]}}, BE=4'b0001<<a.
  - SH: WData={2{d[15:0]}}, BE=a[1]?1100:0011.
  - SW: WData=d, BE=1111.
  - Loads use the same BE pattern with WData=0. NOP: BE=0.
- MEM outputs hold stable while MEM_Valid&&!MEM_Ready.
- SKID_EN=0: FULL is unreachable; EXE_Ready is combinational as stated under Parameters.

Decomposition:
- Package exe_mem_pkg: mem_op_t enum (NOP=0, LB, LBU, LH, LHU, LW, SB, SH, SW); EXC_OV=5'h0C, EXC_ADEL=5'h04, EXC_ADES=5'h05; packed struct exe_mem_entry_t covering every registered field.
- Sub-module mem_lane_gen (combinational): MemOp, addr, data -> WData, BE, misalign flag. Instantiated once on the entry path.

Test Plan:
- Reset mid-stream with FULL asserted -> MEM_Valid=0 and EXE_Ready=1 immediately, with no clock edge needed.
- SB, addr 0x8000_0003, d=0x1234_56AB -> WData=0xABABABAB, BE=1000, MemReq=1, MEM_Valid 1 cycle later.
- SW to 0x8000_0002 -> ExcValid=1, ExcCode=0x05, BadVAddr=0x8000_0002, BE=0, MemReq=0, RegWr=0.
- ADD with Overflow_valid=1 and EXE_ExcValid=1 (code 0x0A) -> ExcCode=0x0A; same with ExcValid=0 -> 0x0C.
- MEM_Ready=0 for 3 cycles with back-to-back entries A, B -> FULL, EXE_Ready=0, A held stable; MEM_Ready=1 -> A then B, EXE_Ready=1 one cycle later.
- Flush while FULL plus a concurrent accept -> next cycle MEM_Valid=0, EXE_Ready=1, and nothing emitted afterwards.
